csel_adder_pipe: RTL and testbench



---
 rtl/csel_adder_pipe.sv | 133 +++++++++++++
 tb/tb_csel_adder_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select adder/subtractor: one SEG-bit segment per stage,
// valid/ready handshake with a single global advance enable.
module csel_adder_pipe #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / SEG;

  if (SEG < 1 || (WIDTH % SEG) != 0) begin : g_bad_param
    $error("csel_adder_pipe: WIDTH must be a positive multiple of SEG");
  end

  // Ripple chain for one segment: returns {carry_out, sum}.
  function automatic logic [SEG:0] ripple(input logic [SEG-1:0] x,
                                          input logic [SEG-1:0] y,
                                          input logic           ci);
    logic [SEG:0]   c;
    logic [SEG-1:0] s;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    return {c[SEG], s};
  endfunction

  logic adv;

  // The whole pipeline moves or freezes together; a full output slot that
  // nobody takes stalls every stage behind it.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int LO     = k * SEG;
    localparam int REM_IN = WIDTH - k * SEG;

    logic [REM_IN-1:0] a_in;
    logic [REM_IN-1:0] b_in;
    logic              c_in;
    logic              v_in;
    logic [LO+SEG-1:0] sum_d;
    logic [SEG:0]      r0;
    logic [SEG:0]      r1;
    logic [SEG-1:0]    s_sel;
    logic              co_sel;

    logic              valid_q;
    logic              carry_q;
    logic [LO+SEG-1:0] sum_q;

    assign r0 = ripple(a_in[SEG-1:0], b_in[SEG-1:0], 1'b0);
    assign r1 = ripple(a_in[SEG-1:0], b_in[SEG-1:0], 1'b1);
    assign {co_sel, s_sel} = c_in ? r1 : r0;

    if (k == 0) begin : g_src
      // Inverting B here plus carry-in = sub forms A + ~B + 1 for subtraction.
      assign a_in  = a;
      assign b_in  = b ^ {WIDTH{sub}};
      assign c_in  = sub;
      assign v_in  = in_valid;
      assign sum_d = s_sel;
    end else begin : g_src
      assign a_in  = g_stage[k-1].g_ops.a_q;
      assign b_in  = g_stage[k-1].g_ops.b_q;
      assign c_in  = g_stage[k-1].carry_q;
      assign v_in  = g_stage[k-1].valid_q;
      assign sum_d = {s_sel, g_stage[k-1].sum_q};
    end

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its predecessor's pre-edge value. Data registers are reset too,
    // so sum/cout/ovf read 0 while rst_n is low, not stale history.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= v_in;
        carry_q <= co_sel;
        sum_q   <= sum_d;
      end
    end

    if (k < NSEG - 1) begin : g_ops
      // Only the operand segments still to be added travel forward.
      logic [REM_IN-SEG-1:0] a_q;
      logic [REM_IN-SEG-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[REM_IN-1:SEG];
          b_q <= b_in[REM_IN-1:SEG];
        end
      end
    end else begin : g_last
      // Carry into the MSB recovered from the selected MSB sum: s ^ a ^ b.
      logic cmsb_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cmsb_q <= 1'b0;
        end else if (adv) begin
          cmsb_q <= s_sel[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1];
        end
      end
    end
  end

  assign out_valid = g_stage[NSEG-1].valid_q;
  assign sum       = g_stage[NSEG-1].sum_q;
  assign cout      = g_stage[NSEG-1].carry_q;
  assign ovf       = g_stage[NSEG-1].carry_q ^ g_stage[NSEG-1].g_last.cmsb_q;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Scoreboard bench for csel_adder_pipe: directed corner cases, stall, reset
// in flight, and random valid/ready traffic against an arithmetic model.
module tb_csel_adder_pipe;

  localparam int WIDTH = 16;
  localparam int SEG   = 4;
  localparam int NSEG  = WIDTH / SEG;
  localparam int N_RAND = 3000;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  always #5 clk = ~clk;

  csel_adder_pipe #(.WIDTH(WIDTH), .SEG(SEG)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  typedef struct {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    int               t_acc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   lat_on   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                 input logic s);
    exp_t           e;
    logic [WIDTH:0] r;
    if (!s) begin
      r      = {1'b0, x} + {1'b0, y};
      e.cout = r[WIDTH];
      e.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end else begin
      r      = {1'b0, x} - {1'b0, y};
      e.cout = ~r[WIDTH];
      e.ovf  = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
    end
    e.sum   = r[WIDTH-1:0];
    e.t_acc = 0;
    return e;
  endfunction

  // Called just after a falling edge with inputs already driven: records the
  // transfers that the next rising edge will perform, then waits one cycle.
  task automatic step(output bit acc);
    exp_t e;
    #1;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("extra_result", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("cout", 32'(cout), 32'(e.cout));
        check("ovf", 32'(ovf), 32'(e.ovf));
        if (lat_on) check("latency", 32'(cyc - e.t_acc), 32'(NSEG));
      end
    end
    acc = in_valid && in_ready;
    if (acc) begin
      e       = model(a, b, sub);
      e.t_acc = cyc;
      sb.push_back(e);
    end
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() > 0; i++) step(acc);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
    bit acc;
    in_valid  = 1'b1;
    a         = x;
    b         = y;
    sub       = s;
    out_ready = 1'b1;
    step(acc);
    check("directed_accept", 32'(acc), 32'd1);
    drain("directed_drain");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               acc;
    int               idx;
    int               issued;
    logic [WIDTH-1:0] ta [6];
    logic [WIDTH-1:0] tb_ops [6];
    logic             ts [6];
    logic [WIDTH-1:0] corner [5];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = '0;
    b         = '0;
    sub       = 1'b0;
    out_ready = 1'b0;
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed corner cases with latency checking.
    lat_on = 1'b1;
    do_op(16'h00FF, 16'h0001, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0);
    do_op(16'h0000, 16'h0001, 1'b1);
    do_op(16'h8000, 16'h0001, 1'b1);
    do_op(16'h1234, 16'h1234, 1'b1);
    do_op(16'h8000, 16'h8000, 1'b0);

    // Six back-to-back ops with a three-cycle output stall.
    lat_on = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ta[i]     = WIDTH'($urandom);
      tb_ops[i] = WIDTH'($urandom);
      ts[i]     = 1'($urandom);
    end
    idx = 0;
    for (int c = 0; c < 30 && (idx < 6 || sb.size() > 0); c++) begin
      in_valid  = (idx < 6);
      a         = ta[idx < 6 ? idx : 0];
      b         = tb_ops[idx < 6 ? idx : 0];
      sub       = ts[idx < 6 ? idx : 0];
      out_ready = !(c >= NSEG && c <= NSEG + 2);
      #1;
      if (c >= NSEG && c <= NSEG + 2) begin
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        check("stall_sum", 32'(sum), 32'(sb[0].sum));
        check("stall_cout", 32'(cout), 32'(sb[0].cout));
        check("stall_ovf", 32'(ovf), 32'(sb[0].ovf));
      end
      if (c >= NSEG + 3 && c <= NSEG + 8) check("b2b_out_valid", 32'(out_valid), 32'd1);
      step(acc);
      if (acc) idx++;
    end
    check("stall_issued", 32'(idx), 32'd6);
    check("stall_delivered", 32'(sb.size()), 32'd0);

    // Reset with one result held at the output and three ops behind it.
    out_ready = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      in_valid = 1'b1;
      a        = WIDTH'(16'h1234 + i);
      b        = WIDTH'(16'h1111);
      sub      = 1'b0;
      step(acc);
    end
    in_valid = 1'b0;
    step(acc);
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_reset_out_valid", 32'(out_valid), 32'd0);
    check("mid_reset_sum", 32'(sum), 32'd0);
    check("mid_reset_cout", 32'(cout), 32'd0);
    check("mid_reset_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) step(acc);
    check("post_reset_idle_valid", 32'(out_valid), 32'd0);
    lat_on = 1'b1;
    do_op(16'hABCD, 16'h1111, 1'b0);

    // Random traffic with random input and output gaps.
    lat_on = 1'b0;
    corner[0] = '0;
    corner[1] = '1;
    corner[2] = 16'h8000;
    corner[3] = 16'h7FFF;
    corner[4] = 16'h0001;
    issued = 0;
    for (int c = 0; c < 20000 && issued < N_RAND; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      sub       = 1'($urandom);
      a = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : WIDTH'($urandom);
      b = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : WIDTH'($urandom);
      step(acc);
      if (acc) issued++;
    end
    check("random_issued", 32'(issued), 32'(N_RAND));
    drain("random_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
